mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
// - Shares one single-port memory between instruction fetch (IF) and the data/MEM stage (load/store).
// - MEM-stage requests come from the decoded memread/memwrite controls.
// - Sequences each access with a req/ack handshake to memory.
// - Returns read data and a one-cycle done pulse to the requester.
// - Drives pipe_stall while any request is outstanding.
// - Sits between the 5-stage pipeline and the unified memory.
// PARAMETERS
// - AW             32  address width
// - DW             32  data width
// - TIMEOUT_CYCLES 64  max cycles waiting for mem_ack; used only with ARB_TIMEOUT_EN
// PORTS
// - clk         in   1   clock; all state on rising edge
// - rst_n       in   1   asynchronous, active-low reset
// - if_req      in   1   fetch request; level, held until if_done
// - if_addr     in   AW  fetch address; stable while if_req=1
// - if_rdata    out  DW  fetched word; valid when if_done=1, held until next fetch completes
// - if_done     out  1   one-cycle completion pulse
// - dm_rd       in   1   load request (memread); level, held until dm_done
// - dm_wr       in   1   store request (memwrite); level, held until dm_done
// - dm_addr     in   AW  data address; stable while request is high
// - dm_wdata    in   DW  store data
// - dm_rdata    out  DW  load data; valid when dm_done=1, held until next load completes
// - dm_done     out  1   one-cycle completion pulse
// - mem_req     out  1   memory request, registered
// - mem_we      out  1   1=write, 0=read
// - mem_addr    out  AW  memory address
// - mem_wdata   out  DW  memory write data
// - mem_rdata   in   DW  memory read data; sampled when mem_ack=1
// - mem_ack     in   1   memory completion; any latency >=0 cycles after mem_req rises
// - pipe_stall  out  1   combinational = (if_req & ~if_done) | ((dm_rd|dm_wr) & ~dm_done)
// - bus_err     out  1   sticky timeout flag; tied 0 without ARB_TIMEOUT_EN
// BEHAVIOUR
// - Reset (async, any state):
//   - state=IDLE.
//   - mem_req, mem_we, mem_addr, mem_wdata, if_rdata, dm_rdata, if_done, dm_done, bus_err, last_grant = 0.
//   - An in-flight access is abandoned; its ack is not awaited.
// - FSM states: IDLE, D_WAIT, I_WAIT, RESP.
// - IDLE, arbitration:
//   - Only data pending -> D_WAIT.
//   - Only fetch pending -> I_WAIT.
//   - Both pending -> data wins unless last_grant=DATA, then fetch wins (alternate).
//   - On grant: register mem_req=1, mem_addr, mem_we (=dm_wr for data, 0 for fetch), mem_wdata; set last_grant.
// - D_WAIT / I_WAIT:
//   - mem_req, mem_addr, mem_we and mem_wdata stay stable until mem_ack.
//   - On mem_ack: mem_req<=0; a read captures mem_rdata into dm_rdata or if_rdata.
//   - Then assert the matching done for one cycle in RESP.
// - RESP: done high exactly one cycle -> IDLE. Requester drops its request at that edge.
// - Latency: request seen in IDLE at cycle 0 -> mem_req=1 at cycle 1.
//   - mem_ack at cycle k -> done at cycle k+1.
//   - Minimum 3 cycles per access; IDLE between accesses.
// - dm_rd & dm_wr both high: treated as a write.
// - mem_ack in IDLE/RESP: ignored.
// - Requests arriving during WAIT/RESP: queued by level, arbitrated in the next IDLE.
// - Writes leave dm_rdata unchanged.
// CONFIGURATION
// - ARB_TIMEOUT_EN defined:
//   - Cycle counter runs in D_WAIT/I_WAIT.
//   - After TIMEOUT_CYCLES cycles without mem_ack: mem_req<=0, go to RESP with done pulse and rdata=0.
//   - bus_err set; cleared only by rst_n.
// - ARB_TIMEOUT_EN undefined: no counter; waits forever for mem_ack; bus_err=0.
// TESTING
// - Load alone: dm_rd=1, addr=0x40, ack 2 cycles after mem_req with rdata=0xDEADBEEF
//   -> mem_we=0, dm_done one cycle, dm_rdata=0xDEADBEEF.
// - Store alone: dm_wr=1, addr=0x80, wdata=0x12345678, immediate ack
//   -> mem_we=1, mem_wdata=0x12345678, dm_done at cycle 2, dm_rdata unchanged.
// - Contention: if_req and dm_rd held together
//   -> data first, fetch second, then alternating; pipe_stall=1 until both dones seen.
// - Reset mid-op: rst_n low during D_WAIT
//   -> mem_req=0 and all outputs 0 immediately; IDLE after release; late ack ignored.
// - Timeout (ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4): fetch never acked
//   -> done after 4 wait cycles, if_rdata=0, bus_err=1 until reset.
// - dm_rd=dm_wr=1 -> single write transaction (mem_we=1).

Source files
------------

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between instruction fetch and the MEM stage
// Ports: clk, rst_n (async active-low)
//   fetch: if_req, if_addr -> if_rdata, if_done
//   data:  dm_rd, dm_wr, dm_addr, dm_wdata -> dm_rdata, dm_done
//   memory: mem_req, mem_we, mem_addr, mem_wdata -> mem_rdata, mem_ack
//   pipe_stall (combinational), bus_err (sticky timeout flag)
// Optional feature: define ARB_TIMEOUT_EN to abandon an access after TIMEOUT_CYCLES without mem_ack.
module mem_port_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_done,
  input  logic          dm_rd,
  input  logic          dm_wr,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_done,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ack,
  output logic          pipe_stall,
  output logic          bus_err
);
  typedef enum logic [1:0] {IDLE, D_WAIT, I_WAIT, RESP} state_t;
  state_t state, state_n;
  logic mem_req_n, mem_we_n, if_done_n, dm_done_n, bus_err_n, last_grant, last_grant_n;
  logic [AW-1:0] mem_addr_n;
  logic [DW-1:0] mem_wdata_n, if_rdata_n, dm_rdata_n;
  logic dm_req, pick_d, timeout;
  assign dm_req = dm_rd | dm_wr;
  // data wins a tie unless it won the previous grant (last_grant=1 means data)
  assign pick_d = dm_req & ~(if_req & last_grant);
  assign pipe_stall = (if_req & ~if_done) | (dm_req & ~dm_done);
`ifdef ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  logic in_wait;
  assign in_wait = (state == D_WAIT) | (state == I_WAIT);
  assign timeout = in_wait & ~mem_ack & (cnt == CW'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else cnt <= in_wait ? cnt + 1'b1 : '0;
`else
  logic [31:0] unused_timeout_cycles;
  assign unused_timeout_cycles = 32'(TIMEOUT_CYCLES);
  assign timeout = 1'b0;
`endif
  always_comb begin
    state_n = state;
    mem_req_n = mem_req;
    mem_we_n = mem_we;
    mem_addr_n = mem_addr;
    mem_wdata_n = mem_wdata;
    if_rdata_n = if_rdata;
    dm_rdata_n = dm_rdata;
    last_grant_n = last_grant;
    if_done_n = 1'b0;
    dm_done_n = 1'b0;
    bus_err_n = bus_err | timeout;
    case (state)
      IDLE: if (dm_req | if_req) begin
        state_n = pick_d ? D_WAIT : I_WAIT;
        mem_req_n = 1'b1;
        mem_we_n = pick_d & dm_wr;
        mem_addr_n = pick_d ? dm_addr : if_addr;
        mem_wdata_n = dm_wdata;
        last_grant_n = pick_d;
      end
      D_WAIT, I_WAIT: if (mem_ack | timeout) begin
        state_n = RESP;
        mem_req_n = 1'b0;
        dm_done_n = state == D_WAIT;
        if_done_n = state == I_WAIT;
        // an abandoned read returns zero
        if (state == D_WAIT && !mem_we) dm_rdata_n = mem_ack ? mem_rdata : '0;
        if (state == I_WAIT) if_rdata_n = mem_ack ? mem_rdata : '0;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      mem_req <= 1'b0;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      if_rdata <= '0;
      dm_rdata <= '0;
      if_done <= 1'b0;
      dm_done <= 1'b0;
      bus_err <= 1'b0;
      last_grant <= 1'b0;
    end else begin
      state <= state_n;
      mem_req <= mem_req_n;
      mem_we <= mem_we_n;
      mem_addr <= mem_addr_n;
      mem_wdata <= mem_wdata_n;
      if_rdata <= if_rdata_n;
      dm_rdata <= dm_rdata_n;
      if_done <= if_done_n;
      dm_done <= dm_done_n;
      bus_err <= bus_err_n;
      last_grant <= last_grant_n;
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized and directed checks of mem_port_arbiter against a transaction-level model
module tb_mem_port_arbiter;
  logic clk = 0, rst_n = 0;
  logic if_req = 0, dm_rd = 0, dm_wr = 0, mem_ack = 0;
  logic [31:0] if_addr = 0, dm_addr = 0, dm_wdata = 0, mem_rdata = 0;
  logic [31:0] if_rdata, dm_rdata, mem_addr, mem_wdata;
  logic if_done, dm_done, mem_req, mem_we, pipe_stall, bus_err;
  always #5 clk = ~clk;
  mem_port_arbiter #(.AW(32), .DW(32), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n), .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
    .if_done(if_done), .dm_rd(dm_rd), .dm_wr(dm_wr), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_done(dm_done), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .pipe_stall(pipe_stall), .bus_err(bus_err));
  int checks = 0, failures = 0;
  logic [31:0] mem [64];
  logic [31:0] ref_mem [64];
  int lat = 1, lat_used = 0, wcnt = 0;
  bit resp_en = 1, stray_ack = 0, acked = 0;
  bit last_data = 0, exp_err = 0;
  logic [31:0] exp_dm = 0, exp_if = 0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s got=%0h exp=%0h", tag, obs, exp);
    end
  endtask
  // memory responder: acks each request after `lat` cycles (0 = same cycle)
  always @(negedge clk) begin
    mem_ack = stray_ack;
    if (!mem_req || !resp_en) begin
      acked = 0;
      wcnt = 0;
    end else if (!acked) begin
      if (wcnt == lat) begin
        mem_ack = 1;
        acked = 1;
        lat_used = lat;
        lat = $urandom_range(0, 3);
        if (mem_we) begin
          mem[mem_addr[7:2]] = mem_wdata;
          mem_rdata = $urandom;
        end else mem_rdata = mem[mem_addr[7:2]];
      end else wcnt++;
    end
  end
  // dk: 0 none, 1 load, 2 store, 3 load+store; dd: cycle at which the data request appears
  task automatic run(input bit wi, input int dk, input int dd, output int dcyc);
    int cyc = 0, gcyc = 0, ldone = 0;
    bit pi = wi, pd = 0, cd = 0, prev = 0;
    logic [31:0] ga = 0;
    if_req = wi;
    if (dd == 0) begin
      dm_rd = (dk % 2) == 1;
      dm_wr = dk >= 2;
      pd = dk != 0;
    end
    while ((pi || pd || cyc < dd) && cyc < 60) begin
      @(posedge clk); #1;
      cyc++;
      chk("stall", pipe_stall, (pi && !if_done) || (pd && !dm_done));
      if (mem_req && !prev) begin
        cd = pd && (!pi || !last_data);
        last_data = cd;
        gcyc = cyc;
        ga = cd ? dm_addr : if_addr;
        chk("grant_cyc", cyc, ldone != 0 ? ldone + 2 : ((wi || dd == 0) ? 1 : dd + 1));
        chk("grant_we", mem_we, cd && dk >= 2);
        chk("grant_addr", mem_addr, ga);
        if (cd && dk >= 2) chk("grant_wdata", mem_wdata, dm_wdata);
      end
      if (mem_req && prev) chk("addr_hold", mem_addr, ga);
      if (if_done || dm_done) begin
        chk("done_who", {if_done, dm_done}, cd ? 2'b01 : 2'b10);
        chk("done_lat", cyc, gcyc + lat_used + 1);
        if (dm_done) begin
          if (dk >= 2) ref_mem[dm_addr[7:2]] = dm_wdata;
          else exp_dm = ref_mem[dm_addr[7:2]];
          chk("dm_rdata", dm_rdata, exp_dm);
          dm_rd = 0;
          dm_wr = 0;
          pd = 0;
        end else begin
          exp_if = ref_mem[if_addr[7:2]];
          chk("if_rdata", if_rdata, exp_if);
          if_req = 0;
          pi = 0;
        end
        ldone = cyc;
      end
      prev = mem_req;
      if (dd > 0 && cyc == dd && dk != 0) begin
        dm_rd = (dk % 2) == 1;
        dm_wr = dk >= 2;
        pd = 1;
      end
    end
    chk("all_done", {pi, pd}, 2'b00);
    chk("bus_err", bus_err, exp_err);
    if_req = 0;
    dm_rd = 0;
    dm_wr = 0;
    @(posedge clk); #1;
    dcyc = ldone;
  endtask
  initial begin
    int d, cyc;
    for (int i = 0; i < 64; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    #12;
    chk("rst_mem_req", mem_req, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_rdata", {if_rdata, dm_rdata}, 0);
    chk("rst_done", {if_done, dm_done}, 0);
    chk("rst_bus_err", bus_err, 0);
    chk("rst_stall", pipe_stall, 0);
    @(negedge clk) rst_n = 1;
    @(posedge clk); #1;
    // contention: data first from reset, then fetch; repeat shows data again (last grant was fetch)
    if_addr = 32'h14; dm_addr = 32'h28;
    run(1, 1, 0, d);
    if_addr = 32'h3c; dm_addr = 32'h44;
    run(1, 1, 0, d);
    run(0, 1, 0, d);
    if_addr = 32'h08; dm_addr = 32'h0c;
    run(1, 1, 0, d);
    // load alone with 2-cycle ack latency
    mem[16] = 32'hDEADBEEF; ref_mem[16] = 32'hDEADBEEF;
    dm_addr = 32'h40; lat = 2;
    run(0, 1, 0, d);
    chk("load_cyc", d, 4);
    chk("load_data", dm_rdata, 32'hDEADBEEF);
    // store alone with immediate ack
    dm_addr = 32'h80; dm_wdata = 32'h12345678; lat = 0;
    run(0, 2, 0, d);
    chk("store_cyc", d, 2);
    chk("store_keeps_rdata", dm_rdata, 32'hDEADBEEF);
    chk("store_mem", mem[32], 32'h12345678);
    // rd and wr together behave as one write
    dm_addr = 32'h84; dm_wdata = 32'hA5A5_0F0F;
    run(0, 3, 0, d);
    chk("both_mem", mem[33], 32'hA5A5_0F0F);
    // reset during D_WAIT, then a stray ack in IDLE
    dm_addr = 32'h10; dm_rd = 1; resp_en = 0;
    @(posedge clk); #1;
    chk("mid_req", mem_req, 1);
    @(posedge clk); #3;
    rst_n = 0;
    #1;
    chk("mid_rst_req", mem_req, 0);
    chk("mid_rst_we_addr", {mem_we, mem_addr, mem_wdata}, 0);
    chk("mid_rst_rdata", {if_rdata, dm_rdata}, 0);
    chk("mid_rst_done", {if_done, dm_done}, 0);
    dm_rd = 0;
    @(negedge clk) rst_n = 1;
    stray_ack = 1; resp_en = 1;
    exp_dm = 0; exp_if = 0; last_data = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("stray_ack_idle", {mem_req, if_done, dm_done}, 0);
    end
    stray_ack = 0;
    @(posedge clk); #1;
    dm_addr = 32'h40;
    run(0, 1, 0, d);
    chk("after_rst_load", dm_rdata, 32'hDEADBEEF);
`ifdef ARB_TIMEOUT_EN
    resp_en = 0; if_addr = 32'h100; if_req = 1; cyc = 0;
    do begin
      @(posedge clk); #1;
      cyc++;
    end while (!if_done && cyc < 20);
    chk("tmo_cyc", cyc, 5);
    chk("tmo_rdata", if_rdata, 0);
    chk("tmo_err", bus_err, 1);
    chk("tmo_req", mem_req, 0);
    if_req = 0; resp_en = 1; exp_if = 0; last_data = 0; exp_err = 1;
    @(posedge clk); #1;
    chk("tmo_err_sticky", bus_err, 1);
    dm_addr = 32'h40;
    run(0, 1, 0, d);
    rst_n = 0;
    #1;
    chk("tmo_err_rst", bus_err, 0);
    @(negedge clk) rst_n = 1;
    exp_err = 0; exp_dm = 0; last_data = 0;
    @(posedge clk); #1;
`else
    cyc = 0;
`endif
    for (int it = 0; it < 40; it++) begin
      bit wi;
      int dk, dd;
      wi = 1'($urandom_range(0, 1));
      dk = $urandom_range(0, 3);
      if (!wi && dk == 0) dk = 1;
      dd = dk != 0 ? $urandom_range(0, 2) : 0;
      if_addr = 32'($urandom_range(0, 63)) << 2;
      dm_addr = 32'($urandom_range(0, 63)) << 2;
      dm_wdata = $urandom;
      run(wi, dk, dd, d);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
